// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one line-wide downstream memory port between
// the instruction-side (read-only) and data-side (read/write) L1 caches.
module l2_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_read,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_resp,
    input  logic          d_read,
    input  logic          d_write,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_resp,
    output logic          pmem_read,
    output logic          pmem_write,
    output logic [AW-1:0] pmem_addr,
    output logic [DW-1:0] pmem_wdata,
    input  logic [DW-1:0] pmem_rdata,
    input  logic          pmem_resp,
    output logic          busy,
    output logic          grant_d
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t state_reg;
    logic   last_d_reg;
    logic   d_req;
    logic   pick_d;
    logic   pick_i;

    // On a tie D wins unless it had the previous grant.
    assign d_req  = d_read | d_write;
    assign pick_d = d_req & (~i_read | ~last_d_reg);
    assign pick_i = i_read & ~pick_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            last_d_reg <= 1'b0;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            pmem_addr  <= '0;
            pmem_wdata <= '0;
            busy       <= 1'b0;
            grant_d    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_d) begin
                        state_reg  <= SERVE_D;
                        last_d_reg <= 1'b1;
                        pmem_read  <= ~d_write;
                        pmem_write <= d_write;
                        pmem_addr  <= d_addr;
                        pmem_wdata <= d_wdata;
                        busy       <= 1'b1;
                        grant_d    <= 1'b1;
                    end else if (pick_i) begin
                        state_reg  <= SERVE_I;
                        last_d_reg <= 1'b0;
                        pmem_read  <= 1'b1;
                        pmem_write <= 1'b0;
                        pmem_addr  <= i_addr;
                        busy       <= 1'b1;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state_reg  <= RECOVER;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                    end
                end
                RECOVER: begin
                    // Requests are ignored here so a just-answered request can drop.
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    grant_d   <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign i_resp  = (state_reg == SERVE_I) & pmem_resp;
    assign d_resp  = (state_reg == SERVE_D) & pmem_resp;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Table-driven bench for l2_port_arbiter with a scoreboard of expected
// downstream commands and a handwritten mid-transaction reset sequence.
module tb_l2_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_read = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_addr;
    logic [DW-1:0] pmem_wdata;
    logic [DW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;
    logic          busy;
    logic          grant_d;

    always #5 clk = ~clk;

    l2_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .busy(busy), .grant_d(grant_d)
    );

    typedef struct {
        bit            ir;
        bit            dr;
        bit            dw;
        logic [AW-1:0] ia;
        logic [AW-1:0] da;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
        int            lat;
        bit            poke;
    } vec_t;

    typedef struct {
        bit            gd;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } exp_t;

    exp_t          sb[$];
    vec_t          vecs[10];
    int            checks = 0;
    int            failures = 0;
    bit            last_d_m = 1'b0;
    logic [DW-1:0] wdata_m = '0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drop_all();
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    // Runs one transaction; called right after a falling edge with the DUT idle.
    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        exp_t g;
        bit   pick_d;
        int   n;
        pick_d = (v.dr || v.dw) && (!v.ir || !last_d_m);
        e.gd   = pick_d;
        e.wr   = pick_d && v.dw;
        e.addr = pick_d ? v.da : v.ia;
        if (pick_d) wdata_m = v.wd;
        e.wdata  = wdata_m;
        last_d_m = pick_d;
        sb.push_back(e);

        i_read = v.ir; i_addr = v.ia;
        d_read = v.dr; d_write = v.dw; d_addr = v.da; d_wdata = v.wd;

        n = 1;
        @(negedge clk);
        while (!(pmem_read || pmem_write) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_latency", DW'(n), DW'(1));
        if (sb.size() == 0) begin
            chk("scoreboard_empty", DW'(0), DW'(1));
            return;
        end
        g = sb.pop_front();
        chk("pmem_write", DW'(pmem_write), DW'(g.wr));
        chk("pmem_read", DW'(pmem_read), DW'(!g.wr));
        chk("pmem_addr", DW'(pmem_addr), DW'(g.addr));
        chk("pmem_wdata", pmem_wdata, g.wdata);
        chk("grant_d", DW'(grant_d), DW'(g.gd));
        chk("busy_serve", DW'(busy), DW'(1));

        for (int k = 0; k < v.lat; k++) begin
            if (v.poke) begin
                i_addr = ~v.ia;
                d_addr = ~v.da;
            end
            chk("early_resp", DW'({i_resp, d_resp}), DW'(0));
            @(negedge clk);
            chk("addr_hold", DW'(pmem_addr), DW'(g.addr));
        end

        pmem_rdata = v.rd;
        pmem_resp  = 1'b1;
        #1;
        chk("i_resp", DW'(i_resp), DW'(!g.gd));
        chk("d_resp", DW'(d_resp), DW'(g.gd));
        chk("rdata", g.gd ? d_rdata : i_rdata, v.rd);

        @(negedge clk);
        pmem_resp = 1'b0;
        drop_all();
        #1;
        chk("cmd_clear", DW'({pmem_read, pmem_write}), DW'(0));
        chk("busy_recover", DW'(busy), DW'(1));
        chk("grant_d_recover", DW'(grant_d), DW'(g.gd));
        chk("resp_after", DW'({i_resp, d_resp}), DW'(0));

        @(negedge clk);
        chk("busy_idle", DW'(busy), DW'(0));
        chk("grant_d_idle", DW'(grant_d), DW'(0));
        $display("txn %0d: grant=%s write=%0d addr=%0h", idx, g.gd ? "D" : "I", g.wr, g.addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1, 0, 0, 32'h40,  32'h0,   {DW{1'b0}},        {8{32'hDEADBEEF}}, 3, 0};
        vecs[1] = '{0, 0, 1, 32'h0,   32'h100, {DW{1'b1}},        {8{32'h12345678}}, 2, 0};
        vecs[2] = '{0, 1, 1, 32'h0,   32'h200, {32{8'hA5}},       {8{32'h0BADF00D}}, 1, 0};
        vecs[3] = '{0, 1, 0, 32'h0,   32'h300, {32{8'h3C}},       {8{32'hCAFEBABE}}, 0, 0};
        vecs[4] = '{1, 0, 0, 32'h80,  32'h0,   {DW{1'b0}},        {8{32'h55AA55AA}}, 2, 1};
        vecs[5] = '{1, 0, 1, 32'hC0,  32'h400, {32{8'h5A}},       {8{32'h11111111}}, 1, 0};
        vecs[6] = '{1, 1, 0, 32'hC0,  32'h440, {32{8'h77}},       {8{32'h22222222}}, 2, 0};
        vecs[7] = '{1, 1, 0, 32'hE0,  32'h440, {32{8'h77}},       {8{32'h33333333}}, 0, 1};
        vecs[8] = '{1, 1, 1, 32'h100, 32'h480, {32{8'h81}},       {8{32'h44444444}}, 1, 0};
        vecs[9] = '{0, 1, 0, 32'h0,   32'h4C0, {32{8'h99}},       {8{32'h66666666}}, 3, 1};

        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_grant_d", DW'(grant_d), DW'(0));
        chk("rst_cmd", DW'({pmem_read, pmem_write}), DW'(0));
        chk("rst_addr", DW'(pmem_addr), DW'(0));
        chk("rst_wdata", pmem_wdata, DW'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Reset in the middle of a D write abandons it; a late response is ignored.
        d_write = 1'b1; d_addr = 32'h500; d_wdata = {8{32'hFEEDFACE}};
        @(negedge clk);
        chk("pre_rst_write", DW'(pmem_write), DW'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_cmd", DW'({pmem_read, pmem_write}), DW'(0));
        chk("async_addr", DW'(pmem_addr), DW'(0));
        chk("async_wdata", pmem_wdata, DW'(0));
        chk("async_busy", DW'({busy, grant_d}), DW'(0));
        pmem_resp = 1'b1;
        #1;
        chk("async_resp", DW'({i_resp, d_resp}), DW'(0));
        @(negedge clk);
        drop_all();
        rst_n = 1'b1;
        #1;
        chk("late_resp", DW'({i_resp, d_resp}), DW'(0));
        @(negedge clk);
        chk("late_resp_idle", DW'({i_resp, d_resp, busy}), DW'(0));
        pmem_resp = 1'b0;
        $display("txn reset: mid-transaction reset checked");
        last_d_m = 1'b0;
        wdata_m  = '0;
        @(negedge clk);

        // After reset the first tie must go to D again.
        run_vec(10, vecs[6]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
